// File: rtl/riscv_mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control FSM.
// Opcode, state, writeback-select and PC-source encodings live here.
package riscv_mc_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLui    = 7'b0110111;

  // {wb_sel1, wb_sel2}
  localparam logic [2:0] WbSelPc   = 3'b100;
  localparam logic [2:0] WbSelAlu  = 3'b000;
  localparam logic [2:0] WbSelDmem = 3'b010;
  localparam logic [2:0] WbSelImm  = 3'b001;

  localparam logic [1:0] PcSrcPlus4  = 2'b00;
  localparam logic [1:0] PcSrcBranch = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  function automatic logic is_mem_state(state_e s);
    return (s == StFetch) || (s == StMem);
  endfunction

endpackage

// File: rtl/riscv_op_dec.sv
// Combinational opcode classifier: instruction class, writeback select and illegal flag.
module riscv_op_dec
  import riscv_mc_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jump,
  output logic [2:0] wb_sel,
  output logic       illegal
);

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    wb_sel    = WbSelAlu;
    illegal   = 1'b0;
    case (op)
      OpcLoad: begin
        is_load = 1'b1;
        wb_sel  = WbSelDmem;
      end
      OpcStore:  is_store  = 1'b1;
      OpcBranch: is_branch = 1'b1;
      OpcJal, OpcJalr: begin
        is_jump = 1'b1;
        wb_sel  = WbSelPc;
      end
      OpcLui:                     wb_sel = WbSelImm;
      OpcOp, OpcOpImm, OpcAuipc:  wb_sel = WbSelAlu;
      default:                    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle control FSM for the RV32I core sharing one memory port for fetch and data.
// Optional memory-wait watchdog enabled by defining MEM_TIMEOUT_EN.
module riscv_mc_ctrl
  import riscv_mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic       wb_sel1,
  output logic [1:0] wb_sel2,
  output logic       illegal,
  output logic       err_timeout
);

  if (TIMEOUT_CYCLES == 0) begin : gen_cfg_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e     state_q, state_d;
  logic [6:0] op_q;
  logic       illegal_q, illegal_d;
  logic       timeout_hit;

  logic [6:0] dec_op;
  logic       d_is_load, d_is_store, d_is_branch, d_is_jump, d_illegal;
  logic [2:0] d_wb_sel;

  // In DECODE op_q is not yet loaded, so classify the live opcode there.
  assign dec_op = (state_q == StDecode) ? opcode : op_q;

  riscv_op_dec u_op_dec (
    .op        (dec_op),
    .is_load   (d_is_load),
    .is_store  (d_is_store),
    .is_branch (d_is_branch),
    .is_jump   (d_is_jump),
    .wb_sel    (d_wb_sel),
    .illegal   (d_illegal)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q;
  logic            waiting;

  // Counter is zero in every non-memory state, which covers clearing on FETCH/MEM entry.
  always_comb begin
    waiting     = is_mem_state(state_q) && !mem_ready;
    cnt_d       = waiting ? (cnt_q + CntW'(1)) : '0;
    timeout_hit = waiting && (cnt_d == CntW'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      StFetch: if (mem_ready) state_d = StDecode;
      StDecode: begin
        if (d_illegal) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (d_is_branch)                  state_d = StFetch;
        else if (d_is_load || d_is_store) state_d = StMem;
        else                              state_d = StWb;
      end
      StMem:   if (mem_ready) state_d = d_is_store ? StFetch : StWb;
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
    if (timeout_hit) state_d = StHalt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (state_q == StDecode) op_q <= opcode;
    end
  end

  assign illegal = illegal_q;

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PcSrcPlus4;
    reg_we   = 1'b0;
    wb_sel1  = 1'b0;
    wb_sel2  = 2'b00;
    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      StExec: begin
        if (d_is_branch) begin
          pc_we  = branch_taken;
          pc_src = PcSrcBranch;
        end
      end
      StMem: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = d_is_store;
      end
      StWb: begin
        reg_we             = 1'b1;
        {wb_sel1, wb_sel2} = d_wb_sel;
        if (d_is_jump) begin
          pc_we  = 1'b1;
          pc_src = PcSrcJump;
        end
      end
      default: ;
    endcase
    // Reset parks the FSM in FETCH; keep the port quiet until release.
    if (rst) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_src   = PcSrcPlus4;
      reg_we   = 1'b0;
      wb_sel1  = 1'b0;
      wb_sel2  = 2'b00;
    end
  end

endmodule
